// File: rtl/ysyx_25070198_sram_slave.sv
// SimpleBus single-outstanding SRAM slave with configurable response latency.
// Define SRAM_RAND_DELAY_EN to replace the fixed LATENCY with an LFSR-driven 1..8 cycle delay.
module ysyx_25070198_sram_slave #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         LAT_EFF = (LATENCY < 1) ? 1 : ((LATENCY > 15) ? 15 : LATENCY);
    localparam logic [32:0] SPAN   = 33'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [3:0]  load_val;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic [3:0]  wmask_q;

    logic [31:0] mem [2**DEPTH_LOG2];

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so the delay sequence is fixed by reset.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'h01;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign load_val = {1'b0, lfsr[2:0]};
`else
    assign load_val = 4'(LAT_EFF - 1);
`endif

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                cnt_nx   = load_val;
                state_nx = (load_val == 4'd0) ? RESP : BUSY;
            end
            BUSY: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // On the acceptance edge the request registers are not loaded yet, so use the live bus.
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_wen;
    logic [3:0]  acc_wmask;
    logic [32:0] offset;
    logic        in_range, enter_resp;
    logic [DEPTH_LOG2-1:0] idx;

    assign acc_addr   = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata  = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_wen    = (state == IDLE) ? req_wen   : wen_q;
    assign acc_wmask  = (state == IDLE) ? req_wmask : wmask_q;
    assign offset     = {1'b0, acc_addr} - {1'b0, ADDR_BASE};
    assign in_range   = !offset[32] && (offset < SPAN);
    assign idx        = offset[DEPTH_LOG2+1:2];
    assign enter_resp = (state_nx == RESP);

    // NOTE: the storage array is deliberately left out of reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_wen && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wmask[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wen_q      <= 1'b0;
            wmask_q    <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wen_q   <= req_wen;
                wmask_q <= req_wmask;
            end
            if (enter_resp) begin
                resp_err   <= !in_range;
                resp_rdata <= (!acc_wen && in_range) ? mem[idx] : 32'd0;
            end else begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_ysyx_25070198_sram_slave.sv
// Self-checking bench: four slaves (LATENCY 1, 4, 3, 0) against a word-map reference model.
// With SRAM_RAND_DELAY_EN defined, expected latencies come from an LFSR model seeded at reset.
module tb_ysyx_25070198_sram_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int N = 4;
    localparam int LAT_P [N] = '{1, 4, 3, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  vld, rdy, rv, er;
    logic [31:0]   rd [N];
    logic [31:0]   addr, wdata;
    logic          wen;
    logic [3:0]    wmask;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ysyx_25070198_sram_slave #(
            .ADDR_BASE(BASE), .DEPTH_LOG2(12), .LATENCY(LAT_P[g])
        ) dut (
            .clk(clk), .rst(rst),
            .req_valid(vld[g]), .req_ready(rdy[g]),
            .req_addr(addr), .req_wen(wen), .req_wdata(wdata), .req_wmask(wmask),
            .resp_valid(rv[g]), .resp_rdata(rd[g]), .resp_err(er[g])
        );
    end

    int total = 0;
    int passed = 0;
    int cyc;
    logic [31:0] mem_m [int unsigned];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [63:0] a64;
        a64 = {32'h0, a};
        return (a64 >= 64'(BASE)) && (a64 < 64'(BASE) + 64'h4000);
    endfunction

`ifdef SRAM_RAND_DELAY_EN
    function automatic int lfsr_lat(input int steps);
        logic [7:0] s;
        s = 8'h01;
        repeat (steps) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return int'(s[2:0]) + 1;
    endfunction
`endif

    // One request to the selected slaves, called at a negedge with them idle; returns at the
    // negedge after the slowest response, with all of them idle again.
    task automatic txn(input logic [N-1:0] sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        int lat [N];
        int maxl;
        logic [31:0] exp_rd;
        logic exp_er;
        int unsigned wi;
        maxl = 0;
        exp_er = !in_rng(a);
        wi = (a - BASE) >> 2;
        exp_rd = (w || exp_er) ? 32'd0 : (mem_m.exists(wi) ? mem_m[wi] : 32'hxxxx_xxxx);
        for (int g = 0; g < N; g++) begin
            lat[g] = 0;
            if (sel[g]) begin
                check($sformatf("ready_idle d%0d", g), 32'(rdy[g]), 32'd1);
`ifdef SRAM_RAND_DELAY_EN
                lat[g] = lfsr_lat(cyc);
`else
                lat[g] = (LAT_P[g] < 1) ? 1 : LAT_P[g];
`endif
                if (lat[g] > maxl) maxl = lat[g];
            end
        end
        addr = a; wen = w; wdata = d; wmask = m; vld = sel;
        for (int k = 1; k <= maxl + 1; k++) begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                if (sel[g]) begin
                    check($sformatf("resp_valid d%0d a=%h k=%0d", g, a, k), 32'(rv[g]), 32'(k == lat[g]));
                    check($sformatf("resp_err d%0d a=%h k=%0d", g, a, k), 32'(er[g]),
                          (k == lat[g]) ? 32'(exp_er) : 32'd0);
                    check($sformatf("resp_rdata d%0d a=%h k=%0d", g, a, k), rd[g],
                          (k == lat[g]) ? exp_rd : 32'd0);
                    check($sformatf("req_ready d%0d a=%h k=%0d", g, a, k), 32'(rdy[g]), 32'(k > lat[g]));
                end
            end
            if (k == 1) begin
                // Scramble the bus after acceptance; the slave must use its captured copy.
                vld = '0;
                addr = $urandom; wdata = $urandom; wen = ~w; wmask = 4'($urandom);
            end
        end
        if (w && !exp_er) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) begin
                    if (!mem_m.exists(wi)) mem_m[wi] = 32'h0;
                    mem_m[wi][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] oor [4];
        logic [31:0] a;
        oor = '{BASE - 32'd4, BASE + 32'h4000, 32'hFFFF_FFFC, 32'h0000_0000};
        rst = 1'b1; vld = '0; addr = '0; wdata = '0; wen = 1'b0; wmask = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check($sformatf("reset ready d%0d", g), 32'(rdy[g]), 32'd1);
            check($sformatf("reset resp_valid d%0d", g), 32'(rv[g]), 32'd0);
            check($sformatf("reset resp_rdata d%0d", g), rd[g], 32'd0);
            check($sformatf("reset resp_err d%0d", g), 32'(er[g]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Write then read back.
        txn('1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        txn('1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);

        // Byte-lane masking.
        txn('1, 1'b1, BASE + 32'h14, 32'h1122_3344, 4'hF);
        txn('1, 1'b1, BASE + 32'h14, 32'hAABB_CCDD, 4'b0101);
        txn('1, 1'b0, BASE + 32'h14, 32'h0, 4'h0);
        check("model masked word", mem_m[5], 32'h11BB_33DD);

        // Range boundaries, out-of-range writes, zero-mask write.
        txn('1, 1'b1, BASE, 32'hCAFE_F00D, 4'hF);
        txn('1, 1'b1, BASE + 32'h3FFC, 32'h0BAD_CAFE, 4'hF);
        txn('1, 1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
        txn('1, 1'b1, BASE, 32'h1234_5678, 4'h0);
        txn('1, 1'b0, BASE, 32'h0, 4'h0);
        txn('1, 1'b0, BASE + 32'h3FFE, 32'h0, 4'h0);
        txn('1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
        txn('1, 1'b0, BASE + 32'h4000, 32'h0, 4'h0);
        txn('1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);

`ifndef SRAM_RAND_DELAY_EN
        // LATENCY=4 with req_valid held high: one response per acceptance.
        addr = BASE + 32'h10; wen = 1'b0; wdata = '0; wmask = '0; vld = 4'b0010;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("hold resp_valid k=%0d", k), 32'(rv[1]), 32'(k == 4 || k == 9));
            check($sformatf("hold req_ready k=%0d", k), 32'(rdy[1]), 32'(k == 5 || k >= 10));
            check($sformatf("hold resp_rdata k=%0d", k), rd[1],
                  (k == 4 || k == 9) ? 32'hDEAD_BEEF : 32'd0);
            if (k == 10) vld = '0;
        end

        // Reset while the LATENCY=3 slave is busy with a write.
        txn('1, 1'b1, BASE + 32'h20, 32'h0BAD_F00D, 4'hF);
        addr = BASE + 32'h20; wen = 1'b1; wdata = 32'h1234_5678; wmask = 4'hF; vld = 4'b0100;
        @(negedge clk);
        check("busy before reset", 32'(rdy[2]), 32'd0);
        vld = '0; rst = 1'b1;
        @(negedge clk);
        check("ready after mid-op reset", 32'(rdy), 32'hF);
        check("no resp at reset", 32'(rv), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("no resp after reset k=%0d", k), 32'(rv), 32'h0);
        end
        txn('1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
`endif

        // Back-to-back reads; under the random-delay build each latency follows the LFSR.
        for (int i = 0; i < 16; i++) txn(4'b0001, 1'b0, BASE + 32'h10, 32'h0, 4'h0);

        // Randomised traffic over a small pre-written window plus out-of-range addresses.
        for (int i = 0; i < 8; i++) txn('1, 1'b1, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) a = oor[$urandom_range(0, 3)];
            else a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            txn('1, 1'($urandom), a, $urandom, 4'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
